command_parser: RTL and testbench

Line-oriented terminal command receiver for the avionics debug link. Consumes the byte strobe coming back from the AVR USB bridge (`rx_data`/`new_rx_data`), assembles one line of the form `<letter>[digits]<CR>`, and presents the decoded command and its unsigned decimal argument to the control logic through a valid/ready handshake. Syntax, overflow and dropped-byte conditions are reported as single-cycle error pulses. It is the receive-side counterpart of the debug message transmitter and replaces ad-hoc single-character command decoding.

---
 rtl/cmd_pkg.sv | 49 ++++
 rtl/dec_accum.sv | 53 +++++
 rtl/command_parser.sv | 125 ++++++++++++
 tb/tb_command_parser.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared constants, state encoding and byte classifier for the
// line-oriented debug command receiver.
package cmd_pkg;

    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] SP  = 8'h20;
    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] DEL = 8'h7F;

    localparam logic [1:0] ERR_SYNTAX   = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW = 2'd1;
    localparam logic [1:0] ERR_DROP     = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARG,
        S_HOLD,
        S_DISCARD
    } state_e;

    typedef enum logic [2:0] {
        B_LETTER,
        B_DIGIT,
        B_CR,
        B_IGNORE,
        B_ABORT,
        B_OTHER
    } bclass_e;

    function automatic bclass_e classify(input logic [7:0] b);
        bclass_e c;
        unique case (1'b1)
            (b >= 8'h61 && b <= 8'h7A),
            (b >= 8'h41 && b <= 8'h5A): c = B_LETTER;
            (b >= 8'h30 && b <= 8'h39): c = B_DIGIT;
            (b == CR):                  c = B_CR;
            (b == SP || b == LF):       c = B_IGNORE;
            (b == BS || b == DEL):      c = B_ABORT;
            default:                    c = B_OTHER;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] to_lower(input logic [7:0] b);
        return (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
    endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal argument accumulator: arg = arg*10 + digit with a digit
// counter; ovf_o flags that the offered digit cannot be absorbed.
module dec_accum
    import cmd_pkg::*;
#(
    parameter int ARG_BITS   = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                dig_i,
    input  logic [3:0]          digit_i,
    output logic [ARG_BITS-1:0] arg_o,
    output logic                has_arg_o,
    output logic                ovf_o
);

    localparam int SW = ARG_BITS + 4;

    logic [ARG_BITS-1:0] arg_q;
    logic [3:0]          cnt_q;
    logic                has_q;
    logic [SW-1:0]       wide;
    logic [SW-1:0]       sum;

    // Four guard bits hold any arg*10+9 without wrapping.
    assign wide = {4'b0, arg_q};
    assign sum  = (wide << 3) + (wide << 1) + {{(SW-4){1'b0}}, digit_i};

    assign ovf_o = (cnt_q >= 4'(MAX_DIGITS)) ||
                   (sum[SW-1:ARG_BITS] != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arg_q <= '0;
            cnt_q <= '0;
            has_q <= 1'b0;
        end else if (clr_i) begin
            arg_q <= '0;
            cnt_q <= '0;
            has_q <= 1'b0;
        end else if (dig_i && !ovf_o) begin
            arg_q <= sum[ARG_BITS-1:0];
            cnt_q <= cnt_q + 4'd1;
            has_q <= 1'b1;
        end
    end

    assign arg_o     = arg_q;
    assign has_arg_o = has_q;

endmodule

// File: rtl/command_parser.sv
// Receives "<letter>[digits]<CR>" lines from the byte strobe and offers
// the decoded command over valid/ready, pulsing errors as they occur.
module command_parser
    import cmd_pkg::*;
#(
    parameter int MAX_DIGITS = 5,
    parameter int ARG_BITS   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                new_rx_data,
    input  logic                cmd_ready,
    output logic                cmd_valid,
    output logic [7:0]          cmd_code,
    output logic [ARG_BITS-1:0] cmd_arg,
    output logic                cmd_has_arg,
    output logic                cmd_err,
    output logic [1:0]          err_code
);

    state_e        state_q, state_d;
    logic [7:0]    code_q, code_d;
    logic          err_q, err_d;
    logic [1:0]    ecode_q, ecode_d;
    logic          acc_clr, acc_dig, acc_ovf, acc_has;
    logic [ARG_BITS-1:0] acc_arg;
    bclass_e       cls;

    assign cls = classify(rx_data);

    dec_accum #(
        .ARG_BITS   (ARG_BITS),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (acc_clr),
        .dig_i     (acc_dig),
        .digit_i   (rx_data[3:0]),
        .arg_o     (acc_arg),
        .has_arg_o (acc_has),
        .ovf_o     (acc_ovf)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        err_d   = 1'b0;
        ecode_d = ERR_SYNTAX;
        acc_clr = 1'b0;
        acc_dig = 1'b0;
        unique case (state_q)
            S_IDLE: if (new_rx_data) begin
                unique case (cls)
                    B_LETTER: begin
                        code_d  = to_lower(rx_data);
                        acc_clr = 1'b1;
                        state_d = S_ARG;
                    end
                    B_DIGIT, B_OTHER: begin
                        err_d   = 1'b1;
                        state_d = S_DISCARD;
                    end
                    default: ;
                endcase
            end
            S_ARG: if (new_rx_data) begin
                unique case (cls)
                    B_DIGIT: begin
                        if (acc_ovf) begin
                            err_d   = 1'b1;
                            ecode_d = ERR_OVERFLOW;
                            state_d = S_DISCARD;
                        end else begin
                            acc_dig = 1'b1;
                        end
                    end
                    B_CR:    state_d = S_HOLD;
                    B_ABORT: state_d = S_IDLE;
                    B_IGNORE: ;
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_DISCARD;
                    end
                endcase
            end
            S_HOLD: begin
                // No backpressure upstream: bytes arriving now are lost.
                if (new_rx_data) begin
                    err_d   = 1'b1;
                    ecode_d = ERR_DROP;
                end
                if (cmd_ready) state_d = S_IDLE;
            end
            S_DISCARD: begin
                if (new_rx_data && (cls == B_CR || cls == B_ABORT))
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            err_q   <= 1'b0;
            ecode_q <= ERR_SYNTAX;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            err_q   <= err_d;
            ecode_q <= ecode_d;
        end
    end

    assign cmd_valid   = (state_q == S_HOLD);
    assign cmd_code    = cmd_valid ? code_q : '0;
    assign cmd_arg     = cmd_valid ? acc_arg : '0;
    assign cmd_has_arg = cmd_valid & acc_has;
    assign cmd_err     = err_q;
    assign err_code    = ecode_q;

endmodule

// File: tb/tb_command_parser.sv
// Randomized plus directed bench for command_parser, checked every
// cycle against a line-level behavioural model.
module tb_command_parser;

    localparam int AB = 16;
    localparam int MD = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          new_rx_data = 1'b0;
    logic          cmd_ready = 1'b0;
    logic          cmd_valid;
    logic [7:0]    cmd_code;
    logic [AB-1:0] cmd_arg;
    logic          cmd_has_arg;
    logic          cmd_err;
    logic [1:0]    err_code;

    always #5 clk = ~clk;

    command_parser #(.MAX_DIGITS(MD), .ARG_BITS(AB)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_arg     (cmd_arg),
        .cmd_has_arg (cmd_has_arg),
        .cmd_err     (cmd_err),
        .err_code    (err_code)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: 0 waiting for a letter, 1 collecting a line,
    // 2 command pending, 3 skipping a bad line.
    int     m_mode;
    int     m_code;
    longint m_val;
    int     m_nd;
    bit     m_has;
    bit     m_err;
    int     m_ecode;

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_code = 0; m_val = 0; m_nd = 0;
        m_has = 0; m_err = 0; m_ecode = 0;
    endtask

    task automatic model_step(input int v, input bit stb, input bit rdy);
        bit is_low, is_up, is_let, is_dig, is_cr, is_ign, is_abt;
        bit e;
        int ec;
        longint nv;
        e = 0; ec = 0;
        is_low = (v >= 97 && v <= 122);
        is_up  = (v >= 65 && v <= 90);
        is_let = is_low || is_up;
        is_dig = (v >= 48 && v <= 57);
        is_cr  = (v == 13);
        is_ign = (v == 32 || v == 10);
        is_abt = (v == 8 || v == 127);
        if (m_mode == 2) begin
            if (stb) begin e = 1; ec = 2; end
            if (rdy) m_mode = 0;
        end else if (stb) begin
            if (m_mode == 0) begin
                if (is_let) begin
                    m_code = is_up ? v + 32 : v;
                    m_val = 0; m_nd = 0; m_has = 0;
                    m_mode = 1;
                end else if (!(is_cr || is_ign || is_abt)) begin
                    e = 1; ec = 0; m_mode = 3;
                end
            end else if (m_mode == 1) begin
                if (is_dig) begin
                    nv = m_val * 10 + (v - 48);
                    if (m_nd + 1 > MD || nv >= (64'd1 << AB)) begin
                        e = 1; ec = 1; m_mode = 3;
                    end else begin
                        m_val = nv; m_nd++; m_has = 1;
                    end
                end else if (is_cr) m_mode = 2;
                else if (is_abt) m_mode = 0;
                else if (!is_ign) begin
                    e = 1; ec = 0; m_mode = 3;
                end
            end else begin
                if (is_cr || is_abt) m_mode = 0;
            end
        end
        m_err = e;
        m_ecode = ec;
    endtask

    task automatic compare_model();
        check("valid", cmd_valid, m_mode == 2);
        check("err", cmd_err, m_err);
        check("err_code", err_code, m_ecode);
        if (m_mode == 2) begin
            check("code", cmd_code, m_code);
            check("arg", cmd_arg, m_val);
            check("has_arg", cmd_has_arg, m_has);
        end
    endtask

    // Called at a negedge; returns at the next negedge after checking.
    task automatic cycle(input bit stb, input logic [7:0] b,
                         input bit rdy);
        new_rx_data = stb;
        rx_data     = b;
        cmd_ready   = rdy;
        model_step(int'(b), stb, rdy);
        @(posedge clk);
        @(negedge clk);
        new_rx_data = 1'b0;
        compare_model();
    endtask

    task automatic send(input string s, input bit rdy);
        for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i], rdy);
    endtask

    task automatic async_reset();
        #1;
        rst = 1'b0;
        #1;
        check("rst_valid", cmd_valid, 0);
        check("rst_arg", cmd_arg, 0);
        check("rst_err", cmd_err, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 35) return 8'(48 + $urandom_range(0, 9));
        if (r < 45) return 8'(97 + $urandom_range(0, 25));
        if (r < 50) return 8'(65 + $urandom_range(0, 25));
        if (r < 65) return 8'h0D;
        if (r < 70) return ($urandom_range(0, 1) != 0) ? 8'h20 : 8'h0A;
        if (r < 74) return ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h7F;
        if (r < 80) return 8'($urandom_range(0, 255));
        return 8'h35;
    endfunction

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_valid", cmd_valid, 0);
        check("reset_err", cmd_err, 0);
        check("reset_code", cmd_code, 0);
        check("reset_arg", cmd_arg, 0);
        rst = 1'b1;
        @(negedge clk);
        compare_model();

        send("m123", 1'b1);
        cycle(1'b1, 8'h0D, 1'b1);
        check("m123_valid", cmd_valid, 1);
        check("m123_code", cmd_code, 8'h6D);
        check("m123_arg", cmd_arg, 123);
        check("m123_has", cmd_has_arg, 1);
        cycle(1'b0, 8'h00, 1'b1);
        check("m123_drop", cmd_valid, 0);

        send("D", 1'b0);
        cycle(1'b1, 8'h0D, 1'b0);
        check("D_code", cmd_code, 8'h64);
        check("D_arg", cmd_arg, 0);
        check("D_has", cmd_has_arg, 0);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            check("D_hold", cmd_valid, 1);
        end
        cycle(1'b0, 8'h00, 1'b1);
        check("D_release", cmd_valid, 0);

        send("t6553", 1'b1);
        cycle(1'b1, "6", 1'b1);
        check("ovf_err", cmd_err, 1);
        check("ovf_code", err_code, 1);
        cycle(1'b1, 8'h0D, 1'b1);
        check("ovf_nocmd", cmd_valid, 0);
        send("t65535", 1'b1);
        cycle(1'b1, 8'h0D, 1'b1);
        check("max_valid", cmd_valid, 1);
        check("max_arg", cmd_arg, 65535);
        cycle(1'b0, 8'h00, 1'b1);

        cycle(1'b1, "7", 1'b1);
        check("syn_err", cmd_err, 1);
        check("syn_code", err_code, 0);
        cycle(1'b1, "x", 1'b1);
        check("syn_once", cmd_err, 0);
        cycle(1'b1, 8'h0D, 1'b1);
        check("syn_nocmd", cmd_valid, 0);
        send("r", 1'b1);
        cycle(1'b1, 8'h0D, 1'b1);
        check("r_code", cmd_code, 8'h72);
        cycle(1'b0, 8'h00, 1'b1);

        send("q", 1'b0);
        cycle(1'b1, 8'h0D, 1'b0);
        cycle(1'b1, "a", 1'b0);
        check("drop_err", cmd_err, 1);
        check("drop_code", err_code, 2);
        check("drop_keep", cmd_code, 8'h71);
        cycle(1'b0, 8'h00, 1'b1);
        check("drop_errcode0", err_code, 0);
        send("m4", 1'b1);
        cycle(1'b1, 8'h08, 1'b1);
        cycle(1'b1, 8'h0D, 1'b1);
        check("bs_nocmd", cmd_valid, 0);
        check("bs_noerr", cmd_err, 0);

        send("m9", 1'b0);
        async_reset();
        send("d", 1'b0);
        cycle(1'b1, 8'h0D, 1'b0);
        check("d_arg", cmd_arg, 0);
        check("d_has", cmd_has_arg, 0);
        async_reset();
        check("hold_rst", cmd_valid, 0);

        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 99) < 65, rand_byte(),
                  $urandom_range(0, 99) < 40);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
